// File: rtl/dot_prod_pkg.sv
// Shared definitions for the dot-product scheduler: FSM states,
// address-width helper and fixed-point word width derivation.
package dot_prod_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        RUN,
        DONE
    } state_t;

    // Bits needed to address n entries (at least 1).
    function automatic int unsigned log2(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) w = i + 1;
        end
        return w;
    endfunction

    // Signed fixed-point word: sign + integer + fraction bits.
    function automatic int unsigned bitwidth(input int unsigned qn, input int unsigned qm);
        return qn + qm + 1;
    endfunction

endpackage

// File: rtl/x_vec_buffer.sv
// Input element storage: DEPTH x WIDTH registers, one write port,
// combinational read port. Contents survive reset.
module x_vec_buffer
    import dot_prod_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 18,
    localparam int unsigned AW   = log2(DEPTH)
) (
    input  logic             clock,
    input  logic             write_en,
    input  logic [AW-1:0]    write_addr,
    input  logic [WIDTH-1:0] write_data,
    input  logic [AW-1:0]    read_addr,
    output logic [WIDTH-1:0] read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store one element per accepted write.
    always_ff @(posedge clock) begin
        if (write_en) mem[write_addr] <= write_data;
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/dot_prod_scheduler.sv
// Dot-product scheduler: loads weight columns into an external weight
// RAM, buffers the input vector, runs the external datapath and holds
// the result until it is taken.
// Optional: define DOT_PROD_TIMEOUT_EN for a RUN watchdog that ends the
// run with error=1 and a zero result after TIMEOUT_CYCLES.
module dot_prod_scheduler
    import dot_prod_pkg::*;
#(
    parameter int unsigned NROW           = 32,
    parameter int unsigned NCOL           = 4,
    parameter int unsigned QN             = 6,
    parameter int unsigned QM             = 11,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    localparam int unsigned BITWIDTH      = bitwidth(QN, QM),
    localparam int unsigned AW            = log2(NCOL)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     cfgWeights,
    output logic                     busy,
    input  logic [NROW*BITWIDTH-1:0] wData,
    input  logic                     wValid,
    output logic                     wReady,
    input  logic [BITWIDTH-1:0]      xData,
    input  logic                     xValid,
    output logic                     xReady,
    output logic [AW-1:0]            wramAddrWrite,
    output logic                     wramWriteEn,
    output logic [NROW*BITWIDTH-1:0] wramDataIn,
    output logic                     dpReset,
    input  logic [AW-1:0]            dpColAddr,
    output logic [BITWIDTH-1:0]      dpInputVec,
    input  logic                     dpDataReady,
    input  logic [NROW*BITWIDTH-1:0] dpOutputVec,
    output logic [NROW*BITWIDTH-1:0] outVec,
    output logic                     outValid,
    input  logic                     outReady,
    output logic                     error
);

    state_t                    state, state_next;
    logic [AW-1:0]             col_cnt;
    logic                      accept_w, accept_x, last_col;
    logic                      ready_prev, ready_rise;
    logic                      wr_en_q;
    logic [AW-1:0]             wr_addr_q;
    logic [NROW*BITWIDTH-1:0]  wr_data_q;
    logic [NROW*BITWIDTH-1:0]  out_q;

`ifdef DOT_PROD_TIMEOUT_EN
    localparam int unsigned TW = log2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] run_cnt;
    logic          timed_out;
    logic          err_q;

    assign timed_out = (state == RUN) && (run_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

    assign last_col   = (col_cnt == AW'(NCOL - 1));
    assign ready_rise = dpDataReady & ~ready_prev;

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        wReady     = 1'b0;
        xReady     = 1'b0;
        accept_w   = 1'b0;
        accept_x   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = cfgWeights ? LOAD_W : LOAD_X;
            end
            LOAD_W: begin
                wReady   = 1'b1;
                accept_w = wValid;
                if (wValid && last_col) state_next = LOAD_X;
            end
            LOAD_X: begin
                xReady   = 1'b1;
                accept_x = xValid;
                if (xValid && last_col) state_next = RUN;
            end
            RUN: begin
                if (ready_rise) state_next = DONE;
`ifdef DOT_PROD_TIMEOUT_EN
                else if (timed_out) state_next = DONE;
`endif
            end
            DONE: begin
                if (outReady) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign dpReset  = (state != RUN);
    assign outValid = (state == DONE);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Column counter shared by weight and input loading; wraps after the last column.
    always_ff @(posedge clock) begin
        if (reset)                     col_cnt <= '0;
        else if (accept_w || accept_x) col_cnt <= last_col ? '0 : col_cnt + 1'b1;
    end

    // Registered weight RAM write, one cycle after each accepted beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= accept_w;
            if (accept_w) begin
                wr_addr_q <= col_cnt;
                wr_data_q <= wData;
            end
        end
    end

    assign wramWriteEn   = wr_en_q;
    assign wramAddrWrite = wr_addr_q;
    assign wramDataIn    = wr_data_q;

    // Previous dpDataReady for rising-edge detection.
    always_ff @(posedge clock) begin
        if (reset) ready_prev <= 1'b0;
        else       ready_prev <= dpDataReady;
    end

    // Result capture at end of RUN; held through DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= '0;
        end else if (state == RUN) begin
            if (ready_rise) out_q <= dpOutputVec;
`ifdef DOT_PROD_TIMEOUT_EN
            else if (timed_out) out_q <= '0;
`endif
        end
    end

    assign outVec = out_q;

`ifdef DOT_PROD_TIMEOUT_EN
    // RUN watchdog counter, held at zero outside RUN so it restarts on entry.
    always_ff @(posedge clock) begin
        if (reset)             run_cnt <= '0;
        else if (state == RUN) run_cnt <= run_cnt + 1'b1;
        else                   run_cnt <= '0;
    end

    // Error flag: cleared by a normal completion, set by watchdog expiry.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == RUN) begin
            if (ready_rise)     err_q <= 1'b0;
            else if (timed_out) err_q <= 1'b1;
        end
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    x_vec_buffer #(
        .DEPTH (NCOL),
        .WIDTH (BITWIDTH)
    ) u_x_buf (
        .clock      (clock),
        .write_en   (accept_x),
        .write_addr (col_cnt),
        .write_data (xData),
        .read_addr  (dpColAddr),
        .read_data  (dpInputVec)
    );

endmodule

// File: tb/tb_dot_prod_scheduler.sv
// Self-checking bench for dot_prod_scheduler with a behavioural weight
// RAM and dot-product engine, and a reference model of expected results.
module tb_dot_prod_scheduler;

    localparam int NROW = 32;
    localparam int NCOL = 4;
    localparam int QN   = 6;
    localparam int QM   = 11;
    localparam int BW   = QN + QM + 1;
    localparam int TMO  = 16;

    logic                 clock = 1'b0;
    logic                 reset, start, cfgWeights, busy;
    logic [NROW*BW-1:0]   wData;
    logic                 wValid, wReady;
    logic [BW-1:0]        xData;
    logic                 xValid, xReady;
    logic [1:0]           wramAddrWrite;
    logic                 wramWriteEn;
    logic [NROW*BW-1:0]   wramDataIn;
    logic                 dpReset;
    logic [1:0]           dpColAddr;
    logic [BW-1:0]        dpInputVec;
    logic                 dpDataReady;
    logic [NROW*BW-1:0]   dpOutputVec;
    logic [NROW*BW-1:0]   outVec;
    logic                 outValid, outReady, error;

    int tests = 0;
    int fails = 0;
    int run_cycles;

    always #5 clock = ~clock;

    dot_prod_scheduler #(
        .NROW           (NROW),
        .NCOL           (NCOL),
        .QN             (QN),
        .QM             (QM),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .cfgWeights    (cfgWeights),
        .busy          (busy),
        .wData         (wData),
        .wValid        (wValid),
        .wReady        (wReady),
        .xData         (xData),
        .xValid        (xValid),
        .xReady        (xReady),
        .wramAddrWrite (wramAddrWrite),
        .wramWriteEn   (wramWriteEn),
        .wramDataIn    (wramDataIn),
        .dpReset       (dpReset),
        .dpColAddr     (dpColAddr),
        .dpInputVec    (dpInputVec),
        .dpDataReady   (dpDataReady),
        .dpOutputVec   (dpOutputVec),
        .outVec        (outVec),
        .outValid      (outValid),
        .outReady      (outReady),
        .error         (error)
    );

    // Signed fixed-point multiply, truncated back to the word format.
    function automatic logic [BW-1:0] fxmul(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic signed [2*BW-1:0] p;
        p = $signed(a) * $signed(b);
        return p[QM +: BW];
    endfunction

    // ---------------- external weight RAM and engine ----------------
    logic [NROW*BW-1:0] wram [NCOL];
    int                 wr_total = 0;
    logic [1:0]         wr_log [64];

    always @(posedge clock) begin
        if (wramWriteEn) begin
            wram[wramAddrWrite]      <= wramDataIn;
            wr_log[wr_total % 64]    <= wramAddrWrite;
            wr_total                 <= wr_total + 1;
        end
    end

    logic       hold_dp = 1'b0;
    logic [2:0] eng_cnt;
    logic [BW-1:0] eng_acc [NROW];

    assign dpColAddr = eng_cnt[1:0];

    always @(posedge clock) begin
        if (dpReset) begin
            eng_cnt     <= '0;
            dpDataReady <= 1'b0;
            for (int r = 0; r < NROW; r++) eng_acc[r] <= '0;
        end else if (!hold_dp && !dpDataReady) begin
            if (eng_cnt < 3'(NCOL)) begin
                for (int r = 0; r < NROW; r++)
                    eng_acc[r] <= eng_acc[r] + fxmul(wram[eng_cnt[1:0]][r*BW +: BW], dpInputVec);
                eng_cnt <= eng_cnt + 1'b1;
            end else begin
                for (int r = 0; r < NROW; r++) dpOutputVec[r*BW +: BW] <= eng_acc[r];
                dpDataReady <= 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [BW-1:0] mw [NCOL][NROW];   // weights currently held in the RAM
    logic [BW-1:0] mx [NCOL];         // input vector for the next run

    function automatic logic [NROW*BW-1:0] expect_vec();
        logic [NROW*BW-1:0] v;
        logic [BW-1:0]      s;
        for (int r = 0; r < NROW; r++) begin
            s = '0;
            for (int c = 0; c < NCOL; c++) s = s + fxmul(mw[c][r], mx[c]);
            v[r*BW +: BW] = s;
        end
        return v;
    endfunction

    function automatic logic [NROW*BW-1:0] pack_col(input int c);
        logic [NROW*BW-1:0] v;
        for (int r = 0; r < NROW; r++) v[r*BW +: BW] = mw[c][r];
        return v;
    endfunction

    function automatic logic [BW-1:0] rnd_fx();
        int v;
        v = int'($urandom_range(0, 8192)) - 4096;
        return v[BW-1:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Start a run, stream weights (optional) and inputs, wait for outValid.
    task automatic run_op(input bit cfg, input bit throttle, input int budget, output bit reached);
        int  c, guard;
        bit  ph, acc;
        start = 1'b1; cfgWeights = cfg;
        tick();
        start = 1'b0; cfgWeights = $urandom_range(0, 1);
        ph = 1'b1;
        if (cfg) begin
            c = 0; guard = 0;
            while (c < NCOL && guard < 100) begin
                wValid = throttle ? ph : 1'b1;
                wData  = wValid ? pack_col(c) : {18{$urandom}};
                acc    = wValid && wReady;
                tick();
                if (acc) c++;
                ph = ~ph; guard++;
            end
            wValid = 1'b0;
        end
        c = 0; guard = 0;
        while (c < NCOL && guard < 100) begin
            xValid = throttle ? ph : 1'b1;
            xData  = xValid ? mx[c] : BW'($urandom);
            acc    = xValid && xReady;
            tick();
            if (acc) c++;
            ph = ~ph; guard++;
        end
        xValid = 1'b0;
        run_cycles = 0; guard = 0;
        while (!outValid && guard < budget) begin
            if (!dpReset) run_cycles++;
            tick();
            guard++;
        end
        reached = outValid;
    endtask

    task automatic release_out();
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        tests++;
        if (outValid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL release: outValid=%b busy=%b, want 0 0", outValid, busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tests++; if (busy !== 1'b0)        begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
        tests++; if (wReady !== 1'b0)      begin fails++; $display("FAIL rst_wready got %b want 0", wReady); end
        tests++; if (xReady !== 1'b0)      begin fails++; $display("FAIL rst_xready got %b want 0", xReady); end
        tests++; if (wramWriteEn !== 1'b0) begin fails++; $display("FAIL rst_we got %b want 0", wramWriteEn); end
        tests++; if (dpReset !== 1'b1)     begin fails++; $display("FAIL rst_dpreset got %b want 1", dpReset); end
        tests++; if (outValid !== 1'b0)    begin fails++; $display("FAIL rst_outvalid got %b want 0", outValid); end
        tests++; if (outVec !== '0)        begin fails++; $display("FAIL rst_outvec got %h want 0", outVec); end
        tests++; if (error !== 1'b0)       begin fails++; $display("FAIL rst_error got %b want 0", error); end
    endtask

    task automatic check_result(input string name, input bit reached, input int wr_base, input int wr_want);
        logic [NROW*BW-1:0] exp_v;
        exp_v = expect_vec();
        tests++;
        if (!reached) begin
            fails++; $display("FAIL %s_timeout: outValid never rose", name);
        end
        tests++;
        if (outVec !== exp_v) begin
            fails++; $display("FAIL %s_outvec lane0 got %h want %h", name, outVec[BW-1:0], exp_v[BW-1:0]);
        end
        tests++;
        if (error !== 1'b0) begin
            fails++; $display("FAIL %s_error got %b want 0", name, error);
        end
        tests++;
        if (wr_total - wr_base !== wr_want) begin
            fails++; $display("FAIL %s_writes got %0d want %0d", name, wr_total - wr_base, wr_want);
        end
    endtask

    task automatic test_full_run(input bit throttle, input string name);
        int  base;
        bit  reached;
        logic [7:0] got_addr, want_addr;
        for (int c = 0; c < NCOL; c++)
            for (int r = 0; r < NROW; r++) mw[c][r] = 18'h00800;
        mx[0] = 18'h00800; mx[1] = 18'h01000; mx[2] = 18'h01800; mx[3] = 18'h02000;
        base = wr_total;
        run_op(1'b1, throttle, 200, reached);
        check_result(name, reached, base, NCOL);
        tests++;
        if (outVec[BW-1:0] !== 18'h05000 || outVec[NROW*BW-1 -: BW] !== 18'h05000) begin
            fails++; $display("FAIL %s_value lane0 got %h want 05000", name, outVec[BW-1:0]);
        end
        want_addr = 8'b11_10_01_00;
        for (int i = 0; i < NCOL; i++) got_addr[i*2 +: 2] = wr_log[(base + i) % 64];
        tests++;
        if (got_addr !== want_addr) begin
            fails++; $display("FAIL %s_addrs got %h want %h", name, got_addr, want_addr);
        end
        release_out();
    endtask

    task automatic test_weight_reuse();
        int base;
        bit reached;
        for (int c = 0; c < NCOL; c++) mx[c] = 18'h00400;
        base = wr_total;
        run_op(1'b0, 1'b0, 200, reached);
        check_result("reuse", reached, base, 0);
        tests++;
        if (outVec[BW-1:0] !== 18'h01000) begin
            fails++; $display("FAIL reuse_value got %h want 01000", outVec[BW-1:0]);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        bit reached;
        logic [NROW*BW-1:0] exp_v;
        for (int c = 0; c < NCOL; c++) mx[c] = rnd_fx();
        run_op(1'b0, 1'b0, 200, reached);
        exp_v = expect_vec();
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            tests++;
            if (outValid !== 1'b1 || busy !== 1'b1 || outVec !== exp_v) begin
                fails++;
                $display("FAIL bp_hold[%0d] outValid=%b busy=%b lane0=%h want 1 1 %h",
                         i, outValid, busy, outVec[BW-1:0], exp_v[BW-1:0]);
            end
            tick();
        end
        start = 1'b0;
        release_out();
    endtask

    task automatic test_reset_mid_load();
        int  base, c, guard;
        bit  acc, reached;
        logic [BW-1:0] nw [NCOL][NROW];
        for (int cc = 0; cc < NCOL; cc++)
            for (int r = 0; r < NROW; r++) nw[cc][r] = rnd_fx();
        base = wr_total;
        start = 1'b1; cfgWeights = 1'b1;
        tick();
        start = 1'b0;
        c = 0; guard = 0;
        while (c < 2 && guard < 50) begin
            wValid = 1'b1;
            for (int r = 0; r < NROW; r++) wData[r*BW +: BW] = nw[c][r];
            acc = wValid && wReady;
            tick();
            if (acc) c++;
            guard++;
        end
        for (int r = 0; r < NROW; r++) wData[r*BW +: BW] = nw[2][r];
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (busy !== 1'b0 || wReady !== 1'b0 || dpReset !== 1'b1 || outValid !== 1'b0) begin
            fails++;
            $display("FAIL midrst_state busy=%b wReady=%b dpReset=%b outValid=%b want 0 0 1 0",
                     busy, wReady, dpReset, outValid);
        end
        repeat (4) tick();
        wValid = 1'b0;
        tests++;
        if (wr_total - base !== 2) begin
            fails++; $display("FAIL midrst_writes got %0d want 2", wr_total - base);
        end
        for (int r = 0; r < NROW; r++) begin
            mw[0][r] = nw[0][r];
            mw[1][r] = nw[1][r];
        end
        // follow-up run reuses the mixed weight set
        for (int cc = 0; cc < NCOL; cc++) mx[cc] = rnd_fx();
        base = wr_total;
        run_op(1'b0, 1'b0, 200, reached);
        check_result("midrst_reuse", reached, base, 0);
        release_out();
    endtask

    task automatic test_timeout();
        bit reached;
        for (int c = 0; c < NCOL; c++) mx[c] = rnd_fx();
        hold_dp = 1'b1;
`ifdef DOT_PROD_TIMEOUT_EN
        run_op(1'b0, 1'b0, 100, reached);
        tests++;
        if (!reached || run_cycles !== TMO) begin
            fails++; $display("FAIL tmo_cycles got %0d (reached=%b) want %0d", run_cycles, reached, TMO);
        end
        tests++; if (error !== 1'b1)    begin fails++; $display("FAIL tmo_error got %b want 1", error); end
        tests++; if (outValid !== 1'b1) begin fails++; $display("FAIL tmo_valid got %b want 1", outValid); end
        tests++; if (outVec !== '0)     begin fails++; $display("FAIL tmo_outvec got %h want 0", outVec[BW-1:0]); end
        hold_dp = 1'b0;
        release_out();
`else
        run_op(1'b0, 1'b0, 40, reached);
        tests++;
        if (reached || error !== 1'b0 || dpReset !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL norun_wait outValid=%b error=%b dpReset=%b busy=%b want 0 0 0 1",
                     outValid, error, dpReset, busy);
        end
        hold_dp = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            tick();
            reached = outValid;
        end
        check_result("norun_late", reached, wr_total, 0);
        release_out();
`endif
    endtask

    task automatic test_random();
        int  base;
        bit  reached, cfg, thr;
        string name;
        for (int n = 0; n < 6; n++) begin
            cfg = $urandom_range(0, 1);
            thr = $urandom_range(0, 1);
            if (cfg)
                for (int c = 0; c < NCOL; c++)
                    for (int r = 0; r < NROW; r++) mw[c][r] = rnd_fx();
            for (int c = 0; c < NCOL; c++) mx[c] = rnd_fx();
            base = wr_total;
            run_op(cfg, thr, 200, reached);
            name = $sformatf("rand%0d", n);
            check_result(name, reached, base, cfg ? NCOL : 0);
            release_out();
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; cfgWeights = 1'b0;
        wData = '0; wValid = 1'b0; xData = '0; xValid = 1'b0; outReady = 1'b0;
        test_reset();
        test_full_run(1'b0, "full");
        test_weight_reuse();
        test_backpressure();
        test_reset_mid_load();
        test_full_run(1'b1, "throttled");
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
